// File: rtl/video_timing_gen.sv
// Video timing generator with pattern source; outputs registered, first pixel 2 clocks after I_EN, no backpressure.
// Define VTG_FRAME_CNT_EN to add the 16-bit O_FRAME_CNT output.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_W    = 8,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic               I_PCLK,
  input  logic               I_RST_N,
  input  logic               I_EN,
  input  logic [1:0]         I_MODE,
  input  logic [3*PIX_W-1:0] I_COLOR,
  output logic [3*PIX_W-1:0] O_PIX_DATA,
  output logic               O_HSYNC,
  output logic               O_VSYNC,
  output logic               O_DE,
  output logic [HW-1:0]      O_X,
  output logic [VW-1:0]      O_Y,
  output logic               O_SOF
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0]        O_FRAME_CNT
`endif
);

  localparam int CW = 3 * PIX_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic            active_q;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic [1:0]      mode_q;
  logic [CW-1:0]   color_q;

  logic            run, h_last, v_last, first;
  logic [31:0]     h32, v32;
  logic [1:0]      mode_sel;
  logic [CW-1:0]   color_sel, pattern;
  logic [2:0]      bar_idx;

  logic            de_d, hs_d, vs_d, sof_d;
  logic [CW-1:0]   pix_d;
  logic [HW-1:0]   x_d;
  logic [VW-1:0]   y_d;
  logic            de_q, hs_q, vs_q, sof_q;
  logic [CW-1:0]   pix_q;
  logic [HW-1:0]   x_q;
  logic [VW-1:0]   y_q;

  // active_q delays counting by one clock so pixel (0,0) lands two clocks after I_EN is seen
  assign run    = active_q && (state_q != S_IDLE);
  assign h32    = 32'(h_q);
  assign v32    = 32'(v_q);
  assign h_last = (h32 == H_TOTAL - 1);
  assign v_last = (v32 == V_TOTAL - 1);
  assign first  = (h_q == '0) && (v_q == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (I_EN) state_d = S_RUN;
      S_RUN:   if (!I_EN) state_d = S_DRAIN;
      S_DRAIN: begin
        if (I_EN) state_d = S_RUN;
        else if (run && h_last && v_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    h_d = '0;
    v_d = '0;
    if (run) begin
      h_d = h_last ? '0 : h_q + 1'b1;
      v_d = v_q;
      if (h_last) v_d = v_last ? '0 : v_q + 1'b1;
    end
  end

  // Pixel (0,0) uses the live inputs, which are latched on the same clock for the rest of the frame
  always_comb begin
    mode_sel  = first ? I_MODE : mode_q;
    color_sel = first ? I_COLOR : color_q;
    bar_idx   = 3'((h32 * 8) / H_ACTIVE);
    pattern   = '0;
    unique case (mode_sel)
      2'd0: pattern = color_sel;
      2'd1: pattern = {{PIX_W{~bar_idx[1]}}, {PIX_W{~bar_idx[2]}}, {PIX_W{~bar_idx[0]}}};
      2'd2: pattern = {3{PIX_W'(h_q)}};
      default: pattern = (h32[5] ^ v32[5]) ? '1 : '0;
    endcase
  end

  always_comb begin
    de_d  = run && (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
    hs_d  = (run && (h32 >= H_ACTIVE + H_FP) && (h32 < H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : ~HS_POL;
    vs_d  = (run && (v32 >= V_ACTIVE + V_FP) && (v32 < V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : ~VS_POL;
    sof_d = run && first;
    pix_d = de_d ? pattern : '0;
    x_d   = run ? h_q : '0;
    y_d   = run ? v_q : '0;
  end

  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q  <= S_IDLE;
      active_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      mode_q   <= '0;
      color_q  <= '0;
      de_q     <= 1'b0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      sof_q    <= 1'b0;
      pix_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= (state_q != S_IDLE);
      h_q      <= h_d;
      v_q      <= v_d;
      if (run && first) begin
        mode_q  <= I_MODE;
        color_q <= I_COLOR;
      end
      de_q     <= de_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      sof_q    <= sof_d;
      pix_q    <= pix_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign O_DE       = de_q;
  assign O_HSYNC    = hs_q;
  assign O_VSYNC    = vs_q;
  assign O_SOF      = sof_q;
  assign O_PIX_DATA = pix_q;
  assign O_X        = x_q;
  assign O_Y        = y_q;

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) frame_cnt_q <= '0;
    else if (sof_d) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign O_FRAME_CNT = frame_cnt_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a reduced 144x14 raster (128x8 active).
module tb_video_timing_gen;

  localparam int HT = 144;
  localparam int VT = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] color = 24'h0;
  logic [23:0] pix;
  logic        hs, vs, de, sof;
  logic [7:0]  ox;
  logic [3:0]  oy;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0] fcnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(128), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .PIX_W(8), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .I_PCLK(clk), .I_RST_N(rst_n), .I_EN(en), .I_MODE(mode), .I_COLOR(color),
    .O_PIX_DATA(pix), .O_HSYNC(hs), .O_VSYNC(vs), .O_DE(de),
    .O_X(ox), .O_Y(oy), .O_SOF(sof)
`ifdef VTG_FRAME_CNT_EN
    , .O_FRAME_CNT(fcnt)
`endif
  );

  task automatic wait_sof(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (sof === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (de !== 1'b0)   begin n_fail++; $display("FAIL reset_de: got %b want 0", de); end
    n_checks++; if (hs !== 1'b1 || vs !== 1'b1) begin n_fail++; $display("FAIL reset_sync: got hs=%b vs=%b want 1/1", hs, vs); end
    n_checks++; if (pix !== 24'h0 || sof !== 1'b0) begin n_fail++; $display("FAIL reset_pix: got pix=%h sof=%b want 0/0", pix, sof); end
    n_checks++; if (ox !== 8'd0 || oy !== 4'd0) begin n_fail++; $display("FAIL reset_xy: got %0d,%0d want 0,0", ox, oy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (de !== 1'b0 || sof !== 1'b0 || hs !== 1'b1 || pix !== 24'h0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL post_reset_idle: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_startup();
    mode = 2'd0; color = 24'h123456; en = 1'b1;
    @(negedge clk);
    n_checks++; if (de !== 1'b0) begin n_fail++; $display("FAIL start_de_c1: got %b want 0", de); end
    @(negedge clk);
    n_checks++; if (de !== 1'b0 || sof !== 1'b0) begin n_fail++; $display("FAIL start_de_c2: got de=%b sof=%b want 0/0", de, sof); end
    @(negedge clk);
    n_checks++; if (de !== 1'b1 || sof !== 1'b1) begin n_fail++; $display("FAIL start_de_c3: got de=%b sof=%b want 1/1", de, sof); end
    n_checks++; if (pix !== 24'h123456) begin n_fail++; $display("FAIL start_pix: got %h want 123456", pix); end
    n_checks++; if (ox !== 8'd0 || oy !== 4'd0) begin n_fail++; $display("FAIL start_xy: got %0d,%0d want 0,0", ox, oy); end
  endtask

  task automatic test_hsync_line();
    int de_cnt = 0, hs_cnt = 0, hs_first = -1, xbad = 0;
    for (int i = 0; i < HT; i++) begin
      if (de === 1'b1) de_cnt++;
      if (hs === 1'b0) begin if (hs_first < 0) hs_first = i; hs_cnt++; end
      if (ox !== 8'(i)) xbad++;
      @(negedge clk);
    end
    n_checks++; if (de_cnt !== 128)  begin n_fail++; $display("FAIL line_de_count: got %0d want 128", de_cnt); end
    n_checks++; if (hs_first !== 132) begin n_fail++; $display("FAIL hsync_start: got %0d want 132", hs_first); end
    n_checks++; if (hs_cnt !== 8)    begin n_fail++; $display("FAIL hsync_width: got %0d want 8", hs_cnt); end
    n_checks++; if (xbad !== 0)      begin n_fail++; $display("FAIL x_sequence: got %0d bad want 0", xbad); end
    n_checks++; if (ox !== 8'd0 || oy !== 4'd1 || de !== 1'b1) begin n_fail++; $display("FAIL line_wrap: got x=%0d y=%0d de=%b want 0,1,1", ox, oy, de); end
  endtask

  task automatic test_frame();
    bit ok;
    int idx = 0, vs_first = -1, vs_cnt = 0, de_cnt = 0, pbad = 0;
`ifdef VTG_FRAME_CNT_EN
    logic [15:0] f0;
`endif
    wait_sof(3000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL frame_sof_wait: got timeout want sof"); end
`ifdef VTG_FRAME_CNT_EN
    f0 = fcnt;
`endif
    do begin
      if (vs === 1'b0) begin if (vs_first < 0) vs_first = idx; vs_cnt++; end
      if (de === 1'b1) begin de_cnt++; if (pix !== 24'h123456) pbad++; end
      else if (pix !== 24'h0) pbad++;
      @(negedge clk);
      idx++;
    end while (sof !== 1'b1 && idx < 5000);
    n_checks++; if (idx !== HT * VT) begin n_fail++; $display("FAIL frame_period: got %0d want 2016", idx); end
    n_checks++; if (vs_first !== 1440) begin n_fail++; $display("FAIL vsync_start: got %0d want 1440", vs_first); end
    n_checks++; if (vs_cnt !== 288)    begin n_fail++; $display("FAIL vsync_width: got %0d want 288", vs_cnt); end
    n_checks++; if (de_cnt !== 1024)   begin n_fail++; $display("FAIL frame_de_count: got %0d want 1024", de_cnt); end
    n_checks++; if (pbad !== 0)        begin n_fail++; $display("FAIL solid_pixels: got %0d bad want 0", pbad); end
`ifdef VTG_FRAME_CNT_EN
    n_checks++; if (fcnt !== f0 + 16'd1) begin n_fail++; $display("FAIL frame_cnt_inc: got %0d want %0d", fcnt, f0 + 16'd1); end
`endif
  endtask

  task automatic test_mode_change();
    bit ok;
    int n = 0;
    mode = 2'd3;
    while (!(ox === 8'd32 && oy === 4'd1) && n < 1000) begin @(negedge clk); n++; end
    n_checks++; if (pix !== 24'h123456) begin n_fail++; $display("FAIL midframe_mode_hold: got %h want 123456", pix); end
    wait_sof(3000, ok);
    n_checks++; if (!ok || pix !== 24'h0 || de !== 1'b1) begin n_fail++; $display("FAIL checker_0_0: got pix=%h de=%b want 000000/1", pix, de); end
    repeat (31) @(negedge clk);
    n_checks++; if (ox !== 8'd31 || pix !== 24'h0) begin n_fail++; $display("FAIL checker_31: got x=%0d pix=%h want 31/000000", ox, pix); end
    @(negedge clk);
    n_checks++; if (pix !== 24'hFFFFFF) begin n_fail++; $display("FAIL checker_32: got %h want ffffff", pix); end
    repeat (32) @(negedge clk);
    n_checks++; if (pix !== 24'h0) begin n_fail++; $display("FAIL checker_64: got %h want 000000", pix); end
    repeat (32) @(negedge clk);
    n_checks++; if (pix !== 24'hFFFFFF) begin n_fail++; $display("FAIL checker_96: got %h want ffffff", pix); end
  endtask

  task automatic test_bars();
    bit ok;
    int bad = 0;
    logic [23:0] line [HT];
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    mode = 2'd1;
    wait_sof(3000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bars_sof_wait: got timeout want sof"); end
    for (int i = 0; i < HT; i++) begin line[i] = pix; @(negedge clk); end
    for (int i = 0; i < 128; i++) if (line[i] !== bars[i / 16]) bad++;
    n_checks++; if (line[0] !== 24'hFFFFFF)   begin n_fail++; $display("FAIL bar_x0: got %h want ffffff", line[0]); end
    n_checks++; if (line[16] !== 24'hFFFF00)  begin n_fail++; $display("FAIL bar_x16: got %h want ffff00", line[16]); end
    n_checks++; if (line[112] !== 24'h000000) begin n_fail++; $display("FAIL bar_x112: got %h want 000000", line[112]); end
    n_checks++; if (line[130] !== 24'h000000) begin n_fail++; $display("FAIL bar_blank: got %h want 000000", line[130]); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bar_line: got %0d bad want 0", bad); end
  endtask

  task automatic test_ramp();
    bit ok;
    int bad = 0;
    logic [23:0] line [HT];
    logic [7:0]  v8;
    mode = 2'd2;
    wait_sof(3000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ramp_sof_wait: got timeout want sof"); end
    for (int i = 0; i < HT; i++) begin line[i] = pix; @(negedge clk); end
    for (int i = 0; i < HT; i++) begin
      v8 = 8'(i);
      if (i < 128 && line[i] !== {v8, v8, v8}) bad++;
      if (i >= 128 && line[i] !== 24'h0) bad++;
    end
    n_checks++; if (line[127] !== 24'h7F7F7F) begin n_fail++; $display("FAIL ramp_x127: got %h want 7f7f7f", line[127]); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ramp_line: got %0d bad want 0", bad); end
  endtask

  task automatic test_drain();
    int n = 0, bad = 0;
    bit found = 1'b0, saw_sof = 1'b0;
    while (oy !== 4'd3 && n < 3000) begin @(negedge clk); n++; end
    en = 1'b0;
    repeat (HT) @(negedge clk);
    en = 1'b1;
    repeat (HT) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (sof === 1'b1) saw_sof = 1'b1;
      if (ox === 8'd143 && oy === 4'd13) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (!found || saw_sof) begin n_fail++; $display("FAIL drain_complete: got found=%b sof=%b want 1/0", found, saw_sof); end
    @(negedge clk);
    n_checks++; if (de !== 1'b0 || hs !== 1'b1 || vs !== 1'b1 || ox !== 8'd0 || oy !== 4'd0) begin n_fail++; $display("FAIL drain_idle: got de=%b hs=%b vs=%b x=%0d y=%0d want 0,1,1,0,0", de, hs, vs, ox, oy); end
    repeat (20) begin @(negedge clk); if (de !== 1'b0 || sof !== 1'b0) bad++; end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL drain_stays_idle: got %0d active want 0", bad); end
    mode = 2'd0; color = 24'hABCDEF; en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (de !== 1'b0) begin n_fail++; $display("FAIL restart_early: got de=%b want 0", de); end
    @(negedge clk);
    n_checks++; if (de !== 1'b1 || sof !== 1'b1 || pix !== 24'hABCDEF) begin n_fail++; $display("FAIL restart_first: got de=%b sof=%b pix=%h want 1,1,abcdef", de, sof, pix); end
  endtask

  task automatic test_async_reset();
    int n = 0, bad = 0;
    while (!(oy === 4'd10 && ox === 8'd5) && n < 3000) begin @(negedge clk); n++; end
    n_checks++; if (vs !== 1'b0) begin n_fail++; $display("FAIL pre_reset_vsync: got %b want 0", vs); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (vs !== 1'b1 || hs !== 1'b1 || de !== 1'b0) begin n_fail++; $display("FAIL arst_sync: got vs=%b hs=%b de=%b want 1,1,0", vs, hs, de); end
    n_checks++; if (pix !== 24'h0 || sof !== 1'b0 || ox !== 8'd0 || oy !== 4'd0) begin n_fail++; $display("FAIL arst_data: got pix=%h sof=%b x=%0d y=%0d want 0", pix, sof, ox, oy); end
`ifdef VTG_FRAME_CNT_EN
    n_checks++; if (fcnt !== 16'd0) begin n_fail++; $display("FAIL arst_frame_cnt: got %0d want 0", fcnt); end
`endif
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin @(negedge clk); if (de !== 1'b0 || vs !== 1'b1 || oy !== 4'd0) bad++; end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL arst_release_idle: got %0d active want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_hsync_line();
    test_frame();
    test_mode_change();
    test_bars();
    test_ramp();
    test_drain();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
